uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8-bit/parity-always transmitter.
- Data width, parity mode (none/even/odd) and stop-bit count are all configurable.
- A valid/ready input handshake feeds an internal FIFO, so frames go out back-to-back without software pacing.
- The baud counter is frame-aligned; it is not free-running.
- Sits between the register/DMA front end and the TX pin.

---
 rtl/uart_tx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter behind a valid/ready FIFO. Frames are sent
// back-to-back with one idle-high cycle between them.
module uart_tx_fifo #(
    parameter int CLK_FREQ    = 10_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_vld,
    output logic                          din_rdy,
    output logic                          TX,
    output logic                          TX_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BIT_W        = $clog2(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  full, push, pop;
    logic [DATA_WIDTH-1:0] head;

    state_e state_q, state_d;

    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign din_rdy = ~full & ~rst;
    assign push    = din_vld & din_rdy;
    // A word pushed into an empty FIFO is not visible to pop until the next cycle.
    assign pop     = (state_q == S_IDLE) && (cnt_q != '0);
    assign head    = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; count and pointers alone decide what is valid,
    // so flushing the FIFO only needs those cleared.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- Transmit FSM ----------------
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;
    logic                  done_c;

    assign bit_end = (baud_q == BAUD_LAST);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_c  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = head;
                    par_d   = (PARITY_MODE == 2) ? ~^head : ^head;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
                        if (PARITY_MODE != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // tx_done marks the final stop-bit cycle, so it can never share a cycle with a pop.
    assign tx_done  = done_c;
    assign TX       = tx_q;
    assign TX_busy  = (state_q != S_IDLE) || (cnt_q != '0);
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: four configurations side by side, a table of single
// frames, directed FIFO/reset sequences and a randomized run against a frame model.
module tb_uart_tx_fifo;

    logic       CLK;
    logic       rst;
    logic [8:0] din_v [4];
    logic [3:0] vld_v;
    logic [3:0] rdy_v, tx_v, busy_v, done_v;
    logic [2:0] cnt_v [4];

    int dw_c [4] = '{8, 8, 8, 7};
    int pm_c [4] = '{1, 2, 0, 1};
    int sb_c [4] = '{1, 1, 1, 2};

    uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
                   .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .CLK(CLK), .rst(rst), .din(din_v[0][7:0]), .din_vld(vld_v[0]), .din_rdy(rdy_v[0]),
        .TX(tx_v[0]), .TX_busy(busy_v[0]), .tx_done(done_v[0]), .fifo_cnt(cnt_v[0]));
    uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
                   .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .CLK(CLK), .rst(rst), .din(din_v[1][7:0]), .din_vld(vld_v[1]), .din_rdy(rdy_v[1]),
        .TX(tx_v[1]), .TX_busy(busy_v[1]), .tx_done(done_v[1]), .fifo_cnt(cnt_v[1]));
    uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .CLK(CLK), .rst(rst), .din(din_v[2][7:0]), .din_vld(vld_v[2]), .din_rdy(rdy_v[2]),
        .TX(tx_v[2]), .TX_busy(busy_v[2]), .tx_done(done_v[2]), .fifo_cnt(cnt_v[2]));
    uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(7),
                   .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
        .CLK(CLK), .rst(rst), .din(din_v[3][6:0]), .din_vld(vld_v[3]), .din_rdy(rdy_v[3]),
        .TX(tx_v[3]), .TX_busy(busy_v[3]), .tx_done(done_v[3]), .fifo_cnt(cnt_v[3]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [8:0] sb [$];
    int         frames_done = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop ones.
    function automatic void model_frame(input int inst, input logic [8:0] w,
                                        output logic [15:0] bits, output int nb);
        int ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < dw_c[inst]; i++) begin
            bits[nb] = w[i];
            ones += int'(w[i]);
            nb++;
        end
        if (pm_c[inst] == 1) begin bits[nb] = ((ones % 2) == 1); nb++; end
        if (pm_c[inst] == 2) begin bits[nb] = ((ones % 2) == 0); nb++; end
        for (int s = 0; s < sb_c[inst]; s++) begin bits[nb] = 1'b1; nb++; end
    endfunction

    // Called on the negedge where the start bit is first seen; returns on the tx_done negedge.
    task automatic check_frame(input int inst, input logic [8:0] w, output int len,
                               output logic [15:0] got, output bit aborted);
        logic [15:0] exp_bits;
        int nb;
        model_frame(inst, w, exp_bits, nb);
        len = 0; got = '0; aborted = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (rst) begin aborted = 1'b1; return; end
            if (c % 10 == 5 && c / 10 < nb) begin
                got[c/10] = tx_v[inst];
                check($sformatf("inst%0d word %0h bit%0d", inst, w, c / 10),
                      32'(tx_v[inst]), 32'(exp_bits[c/10]));
            end
            if (done_v[inst]) begin len = c + 1; return; end
            @(negedge CLK);
        end
        check($sformatf("inst%0d tx_done timeout", inst), 0, 1);
    endtask

    task automatic wait_fall(input int inst, input int limit, output int waited);
        for (waited = 0; waited < limit; waited++) begin
            if (!tx_v[inst]) return;
            @(negedge CLK);
        end
        check($sformatf("inst%0d start bit timeout", inst), 0, 1);
    endtask

    // Starts and ends on a negedge; one rising edge in between.
    task automatic cycle_drive(input int inst, input bit v, input logic [8:0] w, output bit acc);
        din_v[inst] = w;
        vld_v[inst] = v;
        acc = v && rdy_v[inst];
        @(posedge CLK);
        if (acc && inst == 0 && mon_en) sb.push_back(w);
        @(negedge CLK);
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        vld_v[0] = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (!busy_v[0]) begin ok = 1'b1; break; end
        end
        check({name, " drain"}, 32'(ok), 1);
        repeat (3) @(negedge CLK);
        check({name, " scoreboard empty"}, sb.size(), 0);
    endtask

    // Frame monitor for instance 0, fed by the scoreboard of accepted words.
    logic [8:0]  mon_w;
    logic [15:0] mon_got, mon_exp;
    int          mon_len, mon_nb;
    bit          mon_ab, at_edge;
    initial begin
        at_edge = 1'b0;
        forever begin
            if (!at_edge) @(negedge CLK);
            at_edge = 1'b0;
            if (!mon_en || rst) continue;
            if (done_v[0] && tx_v[0]) check("stray tx_done", 1, 0);
            if (!tx_v[0]) begin
                if (sb.size() == 0) begin
                    check("unexpected start bit", 1, 0);
                    mon_w = '0;
                end else begin
                    mon_w = sb.pop_front();
                end
                check_frame(0, mon_w, mon_len, mon_got, mon_ab);
                if (mon_ab) continue;
                model_frame(0, mon_w, mon_exp, mon_nb);
                check("frame length", mon_len, mon_nb * 10);
                check("busy at tx_done", 32'(busy_v[0]), 1);
                frames_done++;
                @(negedge CLK);
                if (rst) continue;
                check("idle cycle TX high", 32'(tx_v[0]), 1);
                check("tx_done one cycle", 32'(done_v[0]), 0);
                if (sb.size() > 0) begin
                    @(negedge CLK);
                    if (!rst) begin
                        check("back-to-back start", 32'(tx_v[0]), 0);
                        at_edge = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         inst;
        logic [8:0] word;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    vec_t        tv [8];
    bit          acc, saw_low;
    int          waited, len, k, peak, f0;
    logic [15:0] got;
    bit          ab;
    logic [8:0]  w;

    initial begin
        tv[0] = '{0, 9'hA5, 110, 1'b0};
        tv[1] = '{1, 9'hA5, 110, 1'b1};
        tv[2] = '{2, 9'hA5, 100, 1'b0};
        tv[3] = '{3, 9'h41, 110, 1'b0};
        tv[4] = '{0, 9'hFF, 110, 1'b0};
        tv[5] = '{1, 9'h00, 110, 1'b1};
        tv[6] = '{0, 9'h01, 110, 1'b1};
        tv[7] = '{3, 9'h7F, 110, 1'b1};

        for (int i = 0; i < 4; i++) din_v[i] = '0;
        vld_v = '0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset TX inst%0d", i), 32'(tx_v[i]), 1);
            check($sformatf("reset din_rdy inst%0d", i), 32'(rdy_v[i]), 0);
        end
        check("reset TX_busy", 32'(busy_v[0]), 0);
        check("reset tx_done", 32'(done_v[0]), 0);
        check("reset fifo_cnt", 32'(cnt_v[0]), 0);
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        #1;
        check("din_rdy after release", 32'(rdy_v[0]), 1);
        @(negedge CLK);

        // Table of single frames across the four configurations.
        foreach (tv[i]) begin
            cycle_drive(tv[i].inst, 1'b1, tv[i].word, acc);
            vld_v[tv[i].inst] = 1'b0;
            check($sformatf("vec%0d accepted", i), 32'(acc), 1);
            wait_fall(tv[i].inst, 20, waited);
            check($sformatf("vec%0d start latency", i), waited, 1);
            check_frame(tv[i].inst, tv[i].word, len, got, ab);
            check($sformatf("vec%0d frame length", i), len, tv[i].exp_len);
            if (pm_c[tv[i].inst] != 0)
                check($sformatf("vec%0d parity", i), 32'(got[dw_c[tv[i].inst] + 1]),
                      32'(tv[i].exp_par));
            @(negedge CLK);
            check($sformatf("vec%0d done width", i), 32'(done_v[tv[i].inst]), 0);
            check($sformatf("vec%0d busy idle", i), 32'(busy_v[tv[i].inst]), 0);
        end

        // Burst: din_vld held high with 0x01..0x06 into a depth-4 FIFO.
        mon_en = 1'b1;
        f0 = frames_done; k = 0; peak = 0;
        for (int c = 0; c < 8; c++) begin
            w = 9'(k + 1);
            cycle_drive(0, 1'b1, w, acc);
            if (acc && k < 5) k++;
            if (int'(cnt_v[0]) > peak) peak = int'(cnt_v[0]);
        end
        vld_v[0] = 1'b0;
        check("burst accepted", k, 5);
        check("burst fifo peak", peak, 4);
        check("burst din_rdy when full", 32'(rdy_v[0]), 0);
        drain("burst");
        check("burst frames sent", frames_done - f0, 5);

        // Push on the same edge as the pop from a FIFO holding three words.
        f0 = frames_done;
        for (int i = 0; i < 4; i++) cycle_drive(0, 1'b1, 9'(8'h30 + i), acc);
        vld_v[0] = 1'b0;
        check("pre-pop fifo_cnt", 32'(cnt_v[0]), 3);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (done_v[0]) break;
        end
        check("first tx_done seen", 32'(done_v[0]), 1);
        @(negedge CLK);
        check("idle fifo_cnt", 32'(cnt_v[0]), 3);
        cycle_drive(0, 1'b1, 9'h5A, acc);
        vld_v[0] = 1'b0;
        check("push during pop accepted", 32'(acc), 1);
        check("push+pop fifo_cnt", 32'(cnt_v[0]), 3);
        drain("push+pop");
        check("push+pop frames sent", frames_done - f0, 5);

        // Reset during data bit 4 with two words queued.
        f0 = frames_done;
        cycle_drive(0, 1'b1, 9'hC3, acc);
        cycle_drive(0, 1'b1, 9'h11, acc);
        cycle_drive(0, 1'b1, 9'h22, acc);
        vld_v[0] = 1'b0;
        repeat (52) @(negedge CLK);
        check("queued before reset", 32'(cnt_v[0]), 2);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("mid-frame reset TX", 32'(tx_v[0]), 1);
        check("mid-frame reset fifo_cnt", 32'(cnt_v[0]), 0);
        check("mid-frame reset busy", 32'(busy_v[0]), 0);
        check("mid-frame reset tx_done", 32'(done_v[0]), 0);
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        #1;
        check("din_rdy after mid-frame reset", 32'(rdy_v[0]), 1);
        saw_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!tx_v[0] || done_v[0]) saw_low = 1'b1;
        end
        check("silent after reset", 32'(saw_low), 0);
        check("aborted frame not completed", frames_done - f0, 0);
        cycle_drive(0, 1'b1, 9'h96, acc);
        vld_v[0] = 1'b0;
        drain("post-reset");
        check("post-reset frame sent", frames_done - f0, 1);

        // Randomized traffic against the scoreboard model.
        f0 = frames_done; k = 0;
        for (int c = 0; c < 3000; c++) begin
            w = 9'($urandom_range(0, 255));
            cycle_drive(0, ($urandom % 8) == 0, w, acc);
            if (acc) k++;
            if (int'(cnt_v[0]) > 4) check("random fifo_cnt bound", 32'(cnt_v[0]), 4);
            if (rdy_v[0] !== (cnt_v[0] != 3'd4)) check("random din_rdy vs full", 32'(rdy_v[0]), 32'(cnt_v[0] != 3'd4));
        end
        drain("random");
        check("random frames sent", frames_done - f0, k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
